cut_bist_ctrl: RTL and testbench
================================

// Module: cut_bist_ctrl
// PURPOSE
//  Built-in self-test sequencer for one combinational benchmark circuit (CUT, e.g. 27-in/27-out
//  ABC netlist). Generates PATTERN_CNT pseudo-random vectors with an LFSR and drives them onto
//  the CUT inputs. Compacts the CUT outputs into a MISR signature and compares it against a
//  golden value. Sits between the dataset harness (start/abort/done) and the CUT instance.
// PARAMETERS
//  IN_W        27          CUT input width (LFSR width)
//  OUT_W       27          CUT output width (MISR width)
//  PATTERN_CNT 1024        vectors applied per run, >=1
//  CUT_LAT     0           CUT output latency in cycles, 0..3 (0 = purely combinational CUT)
//  LFSR_TAPS   27'h4000013 LFSR feedback mask
//  MISR_TAPS   27'h4000013 MISR feedback mask
//  SEED        27'h0000001 LFSR seed; a value of 0 is replaced by 1
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous active-low reset
//  start      in   1      begin run; sampled in IDLE/DONE only
//  abort      in   1      cancel run; highest priority after reset
//  golden     in   OUT_W  expected signature, sampled in the DONE cycle
//  cut_in     out  IN_W   vector driven to CUT inputs
//  cut_out    in   OUT_W  CUT response
//  busy       out  1      high in RUN and DRAIN
//  done       out  1      one-cycle pulse at run completion
//  signature  out  OUT_W  final MISR value; held until next start
//  pass       out  1      signature==golden; valid from done, held until next start/abort
// BEHAVIOUR
//  Reset: state=IDLE; lfsr=SEED (or 1); misr=0; cnt=0; valid pipe=0.
//   Outputs: cut_in=0, busy=0, done=0, signature=0, pass=0.
//  FSM: IDLE -start-> RUN; RUN -(cnt==PATTERN_CNT-1)-> DRAIN, or -> DONE if CUT_LAT==0;
//   DRAIN -(CUT_LAT cycles elapsed)-> DONE; DONE -> IDLE unconditionally.
//   start in DONE -> RUN; this start takes priority over the return to IDLE.
//  Start (edge k): lfsr<=SEED, misr<=0, cnt<=0, pass<=0, signature<=0.
//  RUN, cycles k+1..k+PATTERN_CNT:
//   - cut_in = lfsr;
//   - lfsr <= {lfsr[IN_W-2:0], ^(lfsr & LFSR_TAPS)};
//   - cnt increments.
//  cut_in=0 in every state other than RUN.
//  Capture: the response to the vector applied in cycle c is sampled at the end of cycle c+CUT_LAT,
//   qualified by a CUT_LAT-deep valid shift pipe.
//   MISR update: misr <= {misr[OUT_W-2:0], ^(misr & MISR_TAPS)} ^ cut_out.
//   Exactly PATTERN_CNT updates per run; no update while the valid pipe is 0.
//  DONE cycle (k+PATTERN_CNT+CUT_LAT+1): done=1, busy=0, signature=misr, pass=(misr==golden).
//  start while busy: ignored, with no effect on counters.
//  abort (any state): next state IDLE, busy=0, pass=0, done never pulses, valid pipe cleared.
//   signature keeps its last value. abort and start together: abort wins.
//  rst_n low mid-run: immediate return to reset values; no done pulse.
//  Widths: cnt is $clog2(PATTERN_CNT+1) bits and never wraps within a run.
//   Masks are truncated to IN_W/OUT_W.
// TESTING (IN_W=OUT_W=4, LFSR_TAPS=MISR_TAPS=4'b1100, SEED=4'b0001, PATTERN_CNT=4)
//  T1 CUT_LAT=0, loopback cut_out=cut_in, golden=0000, start pulse
//   -> cut_in 0001,0010,0100,1001 in consecutive cycles; done 5 cycles after start;
//      signature=0000, pass=1.
//  T2 as T1 but bit0 of cut_out inverted during the 2nd vector only
//   -> signature=0100, pass=0.
//  T3 CUT_LAT=2, loopback through a 2-stage register
//   -> busy 6 cycles, done 7 cycles after start; signature=0000, pass=1.
//  T4 abort during 3rd RUN cycle
//   -> IDLE next cycle, busy=0, no done, cut_in=0; a following start reproduces T1 exactly.
//  T5 start held high through the run, then into DONE
//   -> no restart while busy; back-to-back run begins the cycle after DONE, with the same signature.
//  T6 rst_n low for 1 cycle mid-RUN
//   -> all outputs 0 immediately; no done until the next start.

Source files
------------

// File: rtl/cut_bist_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : cut_bist_ctrl
//  Description : BIST sequencer for one combinational benchmark circuit.
//                An LFSR drives PATTERN_CNT pseudo-random vectors onto the
//                CUT inputs, a MISR compacts the (optionally delayed) CUT
//                responses, and the final signature is compared against a
//                golden value supplied by the harness.
//  Revision    : 1.0 - initial release
// ============================================================================
module cut_bist_ctrl #(
  parameter int               IN_W        = 27,
  parameter int               OUT_W       = 27,
  parameter int               PATTERN_CNT = 1024,
  parameter int               CUT_LAT     = 0,
  parameter logic [IN_W-1:0]  LFSR_TAPS   = 27'h4000013,
  parameter logic [OUT_W-1:0] MISR_TAPS   = 27'h4000013,
  parameter logic [IN_W-1:0]  SEED        = 27'h0000001
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [OUT_W-1:0] golden,
  output logic [IN_W-1:0]  cut_in,
  input  logic [OUT_W-1:0] cut_out,
  output logic             busy,
  output logic             done,
  output logic [OUT_W-1:0] signature,
  output logic             pass
);

  localparam int              CNT_W    = $clog2(PATTERN_CNT + 1);
  localparam int              PIPE_W   = (CUT_LAT > 0) ? CUT_LAT : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PATTERN_CNT - 1);
  localparam logic [1:0]      LAT_LAST = 2'((CUT_LAT > 0) ? CUT_LAT - 1 : 0);
  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [IN_W-1:0] SEED_EFF = (SEED == '0) ? IN_W'(1) : SEED;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [IN_W-1:0]   r_lfsr;
  logic [OUT_W-1:0]  r_misr;
  logic [CNT_W-1:0]  r_cnt;
  logic [1:0]        r_dcnt;
  logic [OUT_W-1:0]  r_sig;
  logic              r_pass;
  logic              w_cap_valid;
  logic              w_start_ok;
  logic [IN_W-1:0]   w_lfsr_next;
  logic [OUT_W-1:0]  w_misr_next;

  // start is only honoured between runs, and abort overrides it.
  assign w_start_ok  = start && !abort && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_lfsr_next = {r_lfsr[IN_W-2:0], ^(r_lfsr & LFSR_TAPS)};
  assign w_misr_next = {r_misr[OUT_W-2:0], ^(r_misr & MISR_TAPS)} ^ cut_out;

  // Response qualifier: for a combinational CUT the response is taken in the
  // same cycle as the vector; otherwise a valid bit follows each vector
  // through a CUT_LAT-deep shift pipe.
  generate
    if (CUT_LAT == 0) begin : g_lat0
      assign w_cap_valid = (r_state == S_RUN);
    end else begin : g_latn
      logic [PIPE_W-1:0] r_vpipe;

      // Shift a valid token in for every applied vector; abort flushes it.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_vpipe <= '0;
        end else if (abort) begin
          r_vpipe <= '0;
        end else begin
          r_vpipe <= (r_vpipe << 1) | PIPE_W'(r_state == S_RUN);
        end
      end

      assign w_cap_valid = r_vpipe[PIPE_W-1];
    end
  endgenerate

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; a start in DONE chains straight into the next run.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_RUN;
      S_RUN:   if (r_cnt == CNT_LAST) w_next = (CUT_LAT == 0) ? S_DONE : S_DRAIN;
      S_DRAIN: if (r_dcnt == LAT_LAST) w_next = S_DONE;
      S_DONE:  w_next = start ? S_RUN : S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (abort) begin
      w_next = S_IDLE;
    end
  end

  // Drain counter: cycles spent in DRAIN waiting for the last responses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dcnt <= '0;
    end else if (r_state != S_DRAIN) begin
      r_dcnt <= '0;
    end else begin
      r_dcnt <= r_dcnt + 2'd1;
    end
  end

  // Pattern generator, signature compactor and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr <= SEED_EFF;
      r_misr <= '0;
      r_cnt  <= '0;
      r_sig  <= '0;
      r_pass <= 1'b0;
    end else if (abort) begin
      r_pass <= 1'b0;
    end else if (w_start_ok) begin
      r_lfsr <= SEED_EFF;
      r_misr <= '0;
      r_cnt  <= '0;
      r_sig  <= '0;
      r_pass <= 1'b0;
    end else begin
      if (r_state == S_RUN) begin
        r_lfsr <= w_lfsr_next;
        r_cnt  <= r_cnt + CNT_W'(1);
      end
      if (w_cap_valid) begin
        r_misr <= w_misr_next;
      end
      if (r_state == S_DONE) begin
        r_sig  <= r_misr;
        r_pass <= (r_misr == golden);
      end
    end
  end

  // In the DONE cycle the result is presented directly from the MISR so it
  // is visible together with the done pulse; afterwards the registered copy.
  assign busy      = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign done      = (r_state == S_DONE);
  assign cut_in    = (r_state == S_RUN) ? r_lfsr : '0;
  assign signature = done ? r_misr : r_sig;
  assign pass      = done ? (r_misr == golden) : r_pass;

endmodule
`default_nettype wire

// File: tb/tb_cut_bist_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cut_bist_ctrl
//  Description : Self-checking bench for cut_bist_ctrl. Three instances:
//                4-bit/latency 0, 8-in 6-out/latency 1 (zero seed), and
//                4-bit/latency 2. A behavioural model rebuilds the vector
//                list and the expected signature for each run.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cut_bist_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  start;
  logic [2:0]  abort;
  logic [2:0]  busy;
  logic [2:0]  done;
  logic [2:0]  pass;
  logic [3:0]  golden0, golden2;
  logic [5:0]  golden1;
  logic [3:0]  cut_in0, cut_in2, cut_out0, cut_out2;
  logic [7:0]  cut_in1;
  logic [5:0]  cut_out1;
  logic [3:0]  sig0, sig2;
  logic [5:0]  sig1;

  // CUT model configuration per instance: 0 loopback, 1 loopback with bit0
  // flipped on vector 0010, 2 affine function x*k+c.
  logic [1:0]  cmode [3];
  logic [31:0] ck    [3];
  logic [31:0] cc    [3];
  logic [5:0]  pipe1;
  logic [3:0]  pipe2a, pipe2b;

  int n_checks = 0;
  int n_errors = 0;

  int          cfg_in   [3] = '{4, 8, 4};
  int          cfg_out  [3] = '{4, 6, 4};
  int          cfg_p    [3] = '{4, 10, 4};
  int          cfg_lat  [3] = '{0, 1, 2};
  logic [31:0] cfg_lt   [3] = '{32'hC, 32'hB8, 32'hC};
  logic [31:0] cfg_mt   [3] = '{32'hC, 32'h21, 32'hC};
  logic [31:0] cfg_seed [3] = '{32'h1, 32'h0, 32'h1};

  always #5 clk = ~clk;

  cut_bist_ctrl #(.IN_W(4), .OUT_W(4), .PATTERN_CNT(4), .CUT_LAT(0),
                  .LFSR_TAPS(4'b1100), .MISR_TAPS(4'b1100), .SEED(4'b0001)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .abort(abort[0]), .golden(golden0),
    .cut_in(cut_in0), .cut_out(cut_out0), .busy(busy[0]), .done(done[0]),
    .signature(sig0), .pass(pass[0]));

  cut_bist_ctrl #(.IN_W(8), .OUT_W(6), .PATTERN_CNT(10), .CUT_LAT(1),
                  .LFSR_TAPS(8'hB8), .MISR_TAPS(6'h21), .SEED(8'h00)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .abort(abort[1]), .golden(golden1),
    .cut_in(cut_in1), .cut_out(cut_out1), .busy(busy[1]), .done(done[1]),
    .signature(sig1), .pass(pass[1]));

  cut_bist_ctrl #(.IN_W(4), .OUT_W(4), .PATTERN_CNT(4), .CUT_LAT(2),
                  .LFSR_TAPS(4'b1100), .MISR_TAPS(4'b1100), .SEED(4'b0001)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start[2]), .abort(abort[2]), .golden(golden2),
    .cut_in(cut_in2), .cut_out(cut_out2), .busy(busy[2]), .done(done[2]),
    .signature(sig2), .pass(pass[2]));

  function automatic logic [31:0] wmask(input int w);
    return (32'h1 << w) - 32'h1;
  endfunction

  function automatic logic [31:0] cut_fn(input logic [1:0] mode, input logic [31:0] k,
                                         input logic [31:0] c, input logic [31:0] x,
                                         input int wout);
    logic [31:0] r;
    case (mode)
      2'd0:    r = x;
      2'd1:    r = (x == 32'h2) ? (x ^ 32'h1) : x;
      default: r = x * k + c;
    endcase
    return r & wmask(wout);
  endfunction

  // CUT models: combinational, one register, two registers.
  assign cut_out0 = 4'(cut_fn(cmode[0], ck[0], cc[0], {28'd0, cut_in0}, 4));
  always @(posedge clk) begin
    pipe1  <= 6'(cut_fn(cmode[1], ck[1], cc[1], {24'd0, cut_in1}, 6));
    pipe2a <= 4'(cut_fn(cmode[2], ck[2], cc[2], {28'd0, cut_in2}, 4));
    pipe2b <= pipe2a;
  end
  assign cut_out1 = pipe1;
  assign cut_out2 = pipe2b;

  function automatic logic [31:0] o_cut_in(input int s);
    case (s)
      0:       return {28'd0, cut_in0};
      1:       return {24'd0, cut_in1};
      default: return {28'd0, cut_in2};
    endcase
  endfunction

  function automatic logic [31:0] o_sig(input int s);
    case (s)
      0:       return {28'd0, sig0};
      1:       return {26'd0, sig1};
      default: return {28'd0, sig2};
    endcase
  endfunction

  task automatic set_golden(input int s, input logic [31:0] g);
    case (s)
      0:       golden0 = g[3:0];
      1:       golden1 = g[5:0];
      default: golden2 = g[3:0];
    endcase
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_quiet(input int s, input string tag);
    chk($sformatf("%s s%0d busy", tag, s), {31'd0, busy[s]}, 32'd0);
    chk($sformatf("%s s%0d done", tag, s), {31'd0, done[s]}, 32'd0);
    chk($sformatf("%s s%0d cut_in", tag, s), o_cut_in(s), 32'd0);
  endtask

  // One full run. gsel: 0 golden = expected, 1 golden = expected ^ nonzero,
  // 2 golden = 0. prestarted: start was already taken at the previous edge.
  // hold: keep start high, return in the first cycle of the chained run.
  task automatic do_run(input int s, input bit prestarted, input bit hold,
                        input int gsel, input string nm);
    logic [31:0] v, r, m, fb, gold, mi, mo;
    logic [31:0] vec[$];
    mi = wmask(cfg_in[s]);
    mo = wmask(cfg_out[s]);
    v  = ((cfg_seed[s] & mi) == 32'd0) ? 32'd1 : (cfg_seed[s] & mi);
    m  = 32'd0;
    for (int i = 0; i < cfg_p[s]; i++) begin
      vec.push_back(v);
      r  = cut_fn(cmode[s], ck[s], cc[s], v, cfg_out[s]);
      fb = {31'd0, ^(m & cfg_mt[s])};
      m  = (((m << 1) | fb) ^ r) & mo;
      fb = {31'd0, ^(v & cfg_lt[s])};
      v  = ((v << 1) | fb) & mi;
    end
    case (gsel)
      0:       gold = m;
      1:       gold = m ^ (32'd1 + 32'($urandom_range(0, 32'(mo) - 1)));
      default: gold = 32'd0;
    endcase
    set_golden(s, gold);
    if (!prestarted) begin
      start[s] = 1'b1;
      tick();
      if (!hold) start[s] = 1'b0;
    end
    for (int i = 0; i < cfg_p[s]; i++) begin
      chk($sformatf("%s s%0d vec%0d cut_in", nm, s, i), o_cut_in(s), vec[i]);
      chk($sformatf("%s s%0d vec%0d busy", nm, s, i), {31'd0, busy[s]}, 32'd1);
      chk($sformatf("%s s%0d vec%0d done", nm, s, i), {31'd0, done[s]}, 32'd0);
      tick();
    end
    for (int j = 0; j < cfg_lat[s]; j++) begin
      chk($sformatf("%s s%0d drain%0d busy", nm, s, j), {31'd0, busy[s]}, 32'd1);
      chk($sformatf("%s s%0d drain%0d cut_in", nm, s, j), o_cut_in(s), 32'd0);
      chk($sformatf("%s s%0d drain%0d done", nm, s, j), {31'd0, done[s]}, 32'd0);
      tick();
    end
    chk($sformatf("%s s%0d done", nm, s), {31'd0, done[s]}, 32'd1);
    chk($sformatf("%s s%0d busy@done", nm, s), {31'd0, busy[s]}, 32'd0);
    chk($sformatf("%s s%0d signature", nm, s), o_sig(s), m);
    chk($sformatf("%s s%0d pass", nm, s), {31'd0, pass[s]}, {31'd0, gold == m});
    tick();
    if (hold) return;
    chk($sformatf("%s s%0d done pulse", nm, s), {31'd0, done[s]}, 32'd0);
    chk($sformatf("%s s%0d busy after", nm, s), {31'd0, busy[s]}, 32'd0);
    chk($sformatf("%s s%0d signature held", nm, s), o_sig(s), m);
    chk($sformatf("%s s%0d pass held", nm, s), {31'd0, pass[s]}, {31'd0, gold == m});
  endtask

  initial begin
    int s, ab;
    rst_n = 1'b0;
    start = 3'b000;
    abort = 3'b000;
    golden0 = 4'd0; golden1 = 6'd0; golden2 = 4'd0;
    for (int i = 0; i < 3; i++) begin
      cmode[i] = 2'd0; ck[i] = 32'd0; cc[i] = 32'd0;
    end
    #2;
    for (int i = 0; i < 3; i++) begin
      chk_quiet(i, "reset");
      chk($sformatf("reset s%0d signature", i), o_sig(i), 32'd0);
      chk($sformatf("reset s%0d pass", i), {31'd0, pass[i]}, 32'd0);
    end
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // T1: loopback, golden 0.
    do_run(0, 0, 0, 0, "T1");
    chk("T1 literal signature", o_sig(0), 32'h0);
    // T2: bit0 flipped on the second vector, golden 0.
    cmode[0] = 2'd1;
    do_run(0, 0, 0, 2, "T2");
    chk("T2 literal signature", o_sig(0), 32'h4);
    chk("T2 literal pass", {31'd0, pass[0]}, 32'd0);
    cmode[0] = 2'd0;
    // T3: two-cycle CUT.
    do_run(2, 0, 0, 0, "T3");

    // T4: abort during the third RUN cycle.
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    chk("T4 v0", o_cut_in(0), 32'h1);
    tick();
    chk("T4 v1", o_cut_in(0), 32'h2);
    tick();
    chk("T4 v2", o_cut_in(0), 32'h4);
    abort[0] = 1'b1;
    tick();
    abort[0] = 1'b0;
    chk_quiet(0, "T4 post-abort");
    chk("T4 pass", {31'd0, pass[0]}, 32'd0);
    chk("T4 signature", o_sig(0), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_quiet(0, "T4 idle");
    end
    do_run(0, 0, 0, 0, "T4 rerun");

    // T5: start held high through the run and into DONE.
    do_run(0, 0, 1, 0, "T5a");
    start[0] = 1'b0;
    do_run(0, 1, 0, 0, "T5b");

    // T6: asynchronous reset mid-run.
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    tick();
    chk("T6 running", {31'd0, busy[0]}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk_quiet(0, "T6 in reset");
    chk("T6 signature", o_sig(0), 32'd0);
    chk("T6 pass", {31'd0, pass[0]}, 32'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      chk_quiet(0, "T6 after reset");
      tick();
    end
    do_run(0, 0, 0, 0, "T6 rerun");

    // start and abort together: abort wins.
    start[2] = 1'b1;
    abort[2] = 1'b1;
    tick();
    start[2] = 1'b0;
    abort[2] = 1'b0;
    chk_quiet(2, "start+abort");
    tick();
    chk_quiet(2, "start+abort later");

    // Latency-1 instance with zero seed, loopback then abort in a random cycle.
    do_run(1, 0, 0, 0, "L1");
    ab = $urandom_range(0, 9);
    start[1] = 1'b1;
    tick();
    start[1] = 1'b0;
    for (int i = 0; i < ab; i++) tick();
    abort[1] = 1'b1;
    tick();
    abort[1] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk_quiet(1, "L1 abort");
      tick();
    end

    // Randomized runs with affine CUTs and random golden match/mismatch.
    for (int it = 0; it < 12; it++) begin
      s = $urandom_range(0, 2);
      cmode[s] = 2'd2;
      ck[s] = $urandom;
      cc[s] = $urandom;
      for (int g = $urandom_range(0, 3); g > 0; g--) tick();
      do_run(s, 0, 0, $urandom_range(0, 1), $sformatf("rnd%0d", it));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
